// File: rtl/game_object_ctrl_if.sv
// Frame-sync and game-state bus between the VGA front end and the game object controller.
interface game_object_ctrl_if;
  logic        vSync;
  logic        jump_btn;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [9:0]  obs_x;
  logic [9:0]  obs_y;
  logic        frame_tick;
  logic        collision;
  logic [15:0] score;

  modport master (
    output vSync, jump_btn,
    input  player_x, player_y, obs_x, obs_y, frame_tick, collision, score
  );
  modport slave (
    input  vSync, jump_btn,
    output player_x, player_y, obs_x, obs_y, frame_tick, collision, score
  );
endinterface

// File: rtl/game_object_ctrl.sv
// Player jump FSM, scrolling obstacle, AABB hit detect and score; updates once per frame.
// Optional GAME_SPEEDUP_EN: obstacle speed grows with score (saturates at 8 px/frame).
module game_object_ctrl #(
  parameter int PLAYER_X    = 200,
  parameter int GROUND_Y    = 200,
  parameter int JUMP_HEIGHT = 80,
  parameter int JUMP_STEP   = 4,
  parameter int OBS_Y       = 200,
  parameter int OBS_START   = 400,
  parameter int SCREEN_W    = 640,
  parameter int OBS_SPEED   = 3,
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 16,
  parameter int OBS_W       = 16,
  parameter int OBS_H       = 16
) (
  input logic               clock,
  input logic               clear,
  game_object_ctrl_if.slave bus
);

  localparam logic [9:0] PX    = 10'(PLAYER_X);
  localparam logic [9:0] GND   = 10'(GROUND_Y);
  localparam logic [9:0] TOP_Y = 10'(GROUND_Y - JUMP_HEIGHT);
  localparam logic [9:0] STEP  = 10'(JUMP_STEP);
  localparam logic [9:0] OY    = 10'(OBS_Y);

  typedef enum logic [1:0] {GROUND, RISE, FALL, HIT} state_t;

  state_t      state, nxt_state;
  logic [9:0]  py, nxt_py, ox, nxt_ox, speed;
  logic [15:0] score, nxt_score;
  logic        vsync_q, tick, btn_s1, btn_s2, btn_s3, jump_pend;

  function automatic logic overlap(input logic [9:0] p_y, input logic [9:0] o_x);
    return ({1'b0, PX}  < {1'b0, o_x} + 11'(OBS_W))    &&
           ({1'b0, o_x} < {1'b0, PX}  + 11'(PLAYER_W)) &&
           ({1'b0, p_y} < {1'b0, OY}  + 11'(OBS_H))    &&
           ({1'b0, OY}  < {1'b0, p_y} + 11'(PLAYER_H));
  endfunction

`ifdef GAME_SPEEDUP_EN
  logic [13:0] speed_sum;
  always_comb begin
    speed_sum = 14'(OBS_SPEED) + {1'b0, score[15:3]};
    speed     = (speed_sum > 14'd8) ? 10'd8 : speed_sum[9:0];
  end
`else
  assign speed = 10'(OBS_SPEED);
`endif

  // Frame edge detect, button sync and pending-jump latch
  always_ff @(posedge clock) begin
    if (!clear) begin
      vsync_q   <= 1'b1;
      tick      <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_s3    <= 1'b0;
      jump_pend <= 1'b0;
    end else begin
      vsync_q <= bus.vSync;
      tick    <= vsync_q & ~bus.vSync;
      btn_s1  <= bus.jump_btn;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
      if (tick)                 jump_pend <= 1'b0;
      else if (btn_s2 & ~btn_s3) jump_pend <= 1'b1;
    end
  end

  // State register: everything game-visible moves only on the frame tick
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= GROUND;
      py    <= GND;
      ox    <= 10'(OBS_START);
      score <= '0;
    end else if (tick) begin
      state <= nxt_state;
      py    <= nxt_py;
      ox    <= nxt_ox;
      score <= nxt_score;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_py    = py;
    nxt_ox    = ox;
    nxt_score = score;
    if (state == HIT) begin
      if (jump_pend) begin
        nxt_state = GROUND;
        nxt_py    = GND;
        nxt_ox    = 10'(OBS_START);
        nxt_score = '0;
      end
    end else begin
      case (state)
        GROUND: if (jump_pend) nxt_state = RISE;
        RISE: begin
          nxt_py = py - STEP;
          if (nxt_py <= TOP_Y) begin
            nxt_py    = TOP_Y;
            nxt_state = FALL;
          end
        end
        FALL: begin
          nxt_py = py + STEP;
          if (nxt_py >= GND) begin
            nxt_py    = GND;
            nxt_state = GROUND;
          end
        end
        default: nxt_state = state;
      endcase
      if (ox < speed) begin
        nxt_ox    = 10'(SCREEN_W);
        nxt_score = score + 16'd1;
      end else begin
        nxt_ox = ox - speed;
      end
      // Hit test uses the positions about to be drawn, so a wrap clears it
      if (overlap(nxt_py, nxt_ox)) nxt_state = HIT;
    end
  end

  always_comb begin
    bus.player_x   = PX;
    bus.player_y   = py;
    bus.obs_x      = ox;
    bus.obs_y      = OY;
    bus.frame_tick = tick;
    bus.collision  = (state == HIT);
    bus.score      = score;
  end

endmodule
